// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM state encodings and
// port index values used by ram_arbiter and rr_arbiter_2.
package ram_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] READ   = 2'd2;

    // Port indices
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin picker. The pick is combinational from the current
// requests and the index of the port granted last; 'last' only moves when the
// sequencer pulses 'advance' in its grant cycle.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic granted,
    output logic pick,
    output logic last
);

    // Single requester wins outright; on a conflict the port not granted last wins
    always_comb begin
        pick = PORT0;
        if (req0 && req1) begin
            pick = (last == PORT1) ? PORT0 : PORT1;
        end else if (req1) begin
            pick = PORT1;
        end
    end

    // Remember the most recent winner; starts at PORT1 so PORT0 takes the first conflict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= PORT1;
        end else if (advance) begin
            last <= granted;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer between two masters and one single-port RAM with a
// registered read output. IDLE samples requests, ACCESS drives the command
// and pulses the grant, READ captures RAM data for the winner.
// Optional feature macro: RAM_ARB_BOUNDS_CHECK_EN (flags addresses >= DEPTH,
// suppresses their writes and returns zero for their reads).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 50
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     p0_req,
    input  logic                     p0_we,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    input  logic                     p1_req,
    input  logic                     p1_we,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    output logic                     p0_gnt,
    output logic                     p1_gnt,
    output logic                     p0_rvalid,
    output logic                     p1_rvalid,
    output logic [DATA_WIDTH-1:0]    p0_rdata,
    output logic [DATA_WIDTH-1:0]    p1_rdata,
    output logic                     p0_err,
    output logic                     p1_err,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    // A DEPTH beyond the address space would make the bounds check meaningless
    if (DEPTH < 1 || DEPTH > (2 ** ADDRESS_WIDTH)) begin : g_depth_check
        $error("ram_arbiter: DEPTH must lie in 1 .. 2**ADDRESS_WIDTH");
    end

    logic [1:0]               state;
    logic                     win;
    logic                     cmd_we;
    logic                     cmd_oob;
    logic                     pick;
    logic                     last;
    logic                     advance;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     sel_oob;

    assign advance = (state == ACCESS);

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (p0_req),
        .req1    (p1_req),
        .advance (advance),
        .granted (win),
        .pick    (pick),
        .last    (last)
    );

    // Steer the winning port's command toward the command registers
    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (pick == PORT1) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);
    assign sel_oob = ({1'b0, sel_addr} >= DEPTH_W);
`else
    assign sel_oob = 1'b0;
`endif

    // Sequencer: latch the winner's command, pulse grant, then return read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            win        <= PORT0;
            cmd_we     <= 1'b0;
            cmd_oob    <= 1'b0;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            ram_wEn    <= 1'b0;
            ram_addr   <= '0;
            ram_dataIn <= '0;
        end else begin
            case (state)
                IDLE: begin
                    p0_rvalid <= 1'b0;
                    p1_rvalid <= 1'b0;
                    if (p0_req || p1_req) begin
                        win        <= pick;
                        cmd_we     <= sel_we;
                        cmd_oob    <= sel_oob;
                        ram_addr   <= sel_addr;
                        ram_dataIn <= sel_wdata;
                        ram_wEn    <= sel_we && !sel_oob;
                        p0_gnt     <= (pick == PORT0);
                        p1_gnt     <= (pick == PORT1);
                        p0_err     <= sel_oob && (pick == PORT0);
                        p1_err     <= sel_oob && (pick == PORT1);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    p0_gnt  <= 1'b0;
                    p1_gnt  <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_err  <= 1'b0;
                    ram_wEn <= 1'b0;
                    state   <= cmd_we ? IDLE : READ;
                end
                READ: begin
                    if (win == PORT0) begin
                        p0_rdata  <= cmd_oob ? '0 : ram_dataOut;
                        p0_rvalid <= 1'b1;
                    end else begin
                        p1_rdata  <= cmd_oob ? '0 : ram_dataOut;
                        p1_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 50-word RAM whose read
// output is registered, as the real RAM is. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ram_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int DEP = 50;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    localparam logic OOB_ERR = 1'b1;
    localparam logic OOB_WEN = 1'b0;
`else
    localparam logic OOB_ERR = 1'b0;
    localparam logic OOB_WEN = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:DEP-1];

    always #5 clk = ~clk;

    // Behavioural RAM: write on wEn, registered read, zero beyond DEPTH
    always @(posedge clk) begin
        if (ram_wEn && ram_addr < AW'(DEP)) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= (ram_addr < AW'(DEP)) ? mem[ram_addr] : '0;
    end

    ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEP)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " p0_gnt"}, p0_gnt, 1'b0);
        chk1({tag, " p1_gnt"}, p1_gnt, 1'b0);
        chk1({tag, " p0_rvalid"}, p0_rvalid, 1'b0);
        chk1({tag, " p1_rvalid"}, p1_rvalid, 1'b0);
        chk({tag, " p0_rdata"}, p0_rdata, 32'h0);
        chk({tag, " p1_rdata"}, p1_rdata, 32'h0);
        chk1({tag, " p0_err"}, p0_err, 1'b0);
        chk1({tag, " p1_err"}, p1_err, 1'b0);
        chk1({tag, " ram_wEn"}, ram_wEn, 1'b0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, " ram_dataIn"}, ram_dataIn, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_p1;
        reset_n  = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // p0 writes 0xDEADBEEF to addr 5
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'd5; p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("wr gnt0", p0_gnt, 1'b1);
        chk1("wr gnt1", p1_gnt, 1'b0);
        chk1("wr wEn", ram_wEn, 1'b1);
        chk("wr addr", 32'(ram_addr), 32'd5);
        chk("wr dataIn", ram_dataIn, 32'hDEAD_BEEF);
        chk1("wr err", p0_err, 1'b0);
        p0_req = 1'b0;
        @(negedge clk);
        chk1("wr gnt drop", p0_gnt, 1'b0);
        chk1("wr wEn drop", ram_wEn, 1'b0);

        // p0 reads addr 5 back; rvalid 2 cycles after grant
        p0_req = 1'b1; p0_we = 1'b0;
        @(negedge clk);
        chk1("rd gnt0", p0_gnt, 1'b1);
        chk1("rd wEn", ram_wEn, 1'b0);
        p0_req = 1'b0;
        @(negedge clk);
        chk1("rd rvalid early", p0_rvalid, 1'b0);
        @(negedge clk);
        chk1("rd rvalid", p0_rvalid, 1'b1);
        chk1("rd p1_rvalid", p1_rvalid, 1'b0);
        chk("rd rdata", p0_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk1("rd rvalid pulse", p0_rvalid, 1'b0);
        chk("rd rdata hold", p0_rdata, 32'hDEAD_BEEF);

        // Back-to-back p1 writes to addr 0..3
        p1_req = 1'b1; p1_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p1_addr  = AW'(i);
            p1_wdata = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            chk1("b2b gnt1", p1_gnt, 1'b1);
            chk1("b2b wEn", ram_wEn, 1'b1);
            chk("b2b addr", 32'(ram_addr), 32'(i));
            chk("b2b dataIn", ram_dataIn, 32'h1000_0000 + 32'(i));
            if (i == 3) p1_req = 1'b0;
            @(negedge clk);
            chk1("b2b wEn gap", ram_wEn, 1'b0);
            chk1("b2b gnt gap", p1_gnt, 1'b0);
        end

        // Both ports hold reads: grants alternate starting with p0
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'd2;
        for (int k = 0; k < 6; k++) begin
            exp_p1 = (k % 2) == 1;
            @(negedge clk);
            chk1("rr gnt0", p0_gnt, !exp_p1);
            chk1("rr gnt1", p1_gnt, exp_p1);
            chk("rr addr", 32'(ram_addr), exp_p1 ? 32'd2 : 32'd5);
            @(negedge clk);
            @(negedge clk);
            chk1("rr rvalid0", p0_rvalid, !exp_p1);
            chk1("rr rvalid1", p1_rvalid, exp_p1);
            chk("rr rdata", exp_p1 ? p1_rdata : p0_rdata,
                exp_p1 ? 32'h1000_0002 : 32'hDEAD_BEEF);
            if (k == 5) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
        end

        // Reset during the READ cycle of a p1 read
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'd3;
        @(negedge clk);
        chk1("rst gnt1", p1_gnt, 1'b1);
        p1_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("midrst no rvalid", p1_rvalid, 1'b0);
        end

        // First conflict after reset goes to p0
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'd1;
        @(negedge clk);
        chk1("postrst gnt0", p0_gnt, 1'b1);
        chk1("postrst gnt1", p1_gnt, 1'b0);
        chk("postrst addr", 32'(ram_addr), 32'd0);
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("postrst rvalid0", p0_rvalid, 1'b1);
        chk1("postrst rvalid1", p1_rvalid, 1'b0);
        chk("postrst rdata", p0_rdata, 32'h1000_0000);

        // Out-of-range write to addr 50
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 12'd50; p0_wdata = 32'h55;
        @(negedge clk);
        chk1("oob wr gnt", p0_gnt, 1'b1);
        chk1("oob wr err", p0_err, OOB_ERR);
        chk1("oob wr wEn", ram_wEn, OOB_WEN);
        p0_req = 1'b0;
        @(negedge clk);
        chk1("oob wr err pulse", p0_err, 1'b0);

        // Out-of-range read of addr 60
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'd60;
        @(negedge clk);
        chk1("oob rd gnt", p0_gnt, 1'b1);
        chk1("oob rd err", p0_err, OOB_ERR);
        chk1("oob rd p1_err", p1_err, 1'b0);
        p0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("oob rd rvalid", p0_rvalid, 1'b1);
        chk("oob rd rdata", p0_rdata, 32'h0);
        chk1("oob rd err gone", p0_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the shared single-port data `RAM`. It sits between the processor data-memory port (p0) and a secondary master such as an I/O or display engine (p1). It serialises their requests onto the RAM's `wEn`/`addr`/`dataIn` inputs with round-robin fairness, and returns read data from `dataOut` to the winning port with a fixed latency.

## Interface
- `DATA_WIDTH`, default 32: word width; matches the RAM.
- `ADDRESS_WIDTH`, default 12: address width; matches the RAM.
- `DEPTH`, default 50: number of implemented RAM words; used only by bounds checking.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `p0_req`, `p1_req` in 1: access request; hold high with command stable until grant.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in ADDRESS_WIDTH: word address.
- `p0_wdata`, `p1_wdata` in DATA_WIDTH: write data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle pulse; command accepted and on the RAM this cycle.
- `p0_rvalid`, `p1_rvalid` out 1: one-cycle pulse; `pX_rdata` valid.
- `p0_rdata`, `p1_rdata` out DATA_WIDTH: registered read data; holds its value until the next rvalid for that port.
- `p0_err`, `p1_err` out 1: out-of-range flag; see Configuration.
- `ram_wEn` out 1: to RAM `wEn`.
- `ram_addr` out ADDRESS_WIDTH: to RAM `addr`.
- `ram_dataIn` out DATA_WIDTH: to RAM `dataIn`.
- `ram_dataOut` in DATA_WIDTH: from RAM `dataOut`, registered inside the RAM.

## Operation
- The FSM has three states: IDLE, ACCESS, READ.
- **IDLE**
  - Sample `p0_req`/`p1_req`. With no request, stay in IDLE.
  - Pick a winner:
    - If only one port requests, it wins.
    - If both request, the port not granted last wins.
    - The `last` bit resets to 1, so p0 wins the first conflict.
  - Register the winner's `we`/`addr`/`wdata` onto `ram_wEn`/`ram_addr`/`ram_dataIn`, record the winner index, and go to ACCESS.
- **ACCESS**
  - `pX_gnt` = 1 for the winner. `ram_wEn` is high only for a write.
  - Update `last` to the winner.
  - For a write, go to IDLE and drop `ram_wEn` to 0.
  - For a read, go to READ.
- **READ**
  - `ram_dataOut` is valid in this cycle.
  - Capture it into the winner's `pX_rdata`, pulse `pX_rvalid` in the following cycle, and go to IDLE.
- Requests are sampled only in IDLE.
  - A requester must drop `req` at the edge ending its grant cycle; a `req` still high in IDLE is a new request.
  - A request withdrawn after sampling still completes, including its rvalid.
- `ram_addr`/`ram_dataIn` hold their last values when idle. `ram_wEn` is 0 in every state except ACCESS-with-write.

## Timing
- Reset values: state IDLE, `last` = 1, and every output 0 (`gnt`, `rvalid`, `rdata`, `err`, `ram_wEn`, `ram_addr`, `ram_dataIn`).
- Assertion of `reset_n` mid-operation:
  - Clears all outputs immediately and asynchronously.
  - Discards any in-flight read; no rvalid is issued.
- Latency:
  - `req` sampled at edge E0; `gnt` and RAM command are present in the cycle after E0.
  - The read's `rvalid` is asserted 2 cycles after the `gnt` cycle.
- Throughput:
  - Writes: one per 2 cycles (IDLE, ACCESS).
  - Reads: one per 3 cycles (IDLE, ACCESS, READ).
  - An rvalid cycle overlaps the next IDLE.
- Each of `gnt`, `rvalid` and `err` is high for at most one cycle per access.
- `p0_gnt` and `p1_gnt` are never high together.

## Configuration
- Macro: `RAM_ARB_BOUNDS_CHECK_EN`.
- Defined:
  - When a granted `addr >= DEPTH`, `pX_err` pulses with `pX_gnt` and `ram_wEn` stays 0.
  - A read to such an address still completes with `rvalid` and `rdata` = 0.
- Undefined:
  - The address passes through unchanged.
  - `p0_err`/`p1_err` are tied 0.
  - The comparator is not synthesised.

## Structure
- Package `ram_arb_pkg`:
  - State enum: IDLE = 2'd0, ACCESS = 2'd1, READ = 2'd2.
  - Port index constants `PORT0` = 0, `PORT1` = 1.
- Sub-module `rr_arbiter_2`:
  - Two-request round-robin pick plus the `last` register, with an `advance` input pulsed in ACCESS.
  - The top level holds the FSM, command registers and read-return logic.

## Test plan
- After reset, p0 writes 0xDEADBEEF to addr 5:
  - `p0_gnt` is high one cycle later with `ram_wEn` = 1, addr 5.
  - A later p0 read of addr 5 gives `p0_rvalid` 2 cycles after grant with `p0_rdata` = 0xDEADBEEF.
- p0 and p1 both hold read requests continuously for 6 grants:
  - Grants alternate p0, p1, p0, p1, …
  - Each rvalid reaches only the matching port.
- Back-to-back p1 writes to addr 0..3: `ram_wEn` pulses every 2nd cycle with addresses 0, 1, 2, 3 in order.
- Assert `reset_n` in the READ cycle of a p1 read:
  - All outputs go to 0 immediately and no `p1_rvalid` follows.
  - The next conflict is granted to p0.
- With `RAM_ARB_BOUNDS_CHECK_EN` and DEPTH = 50:
  - A p0 write to addr 50 gives `p0_err` with `gnt` and `ram_wEn` = 0.
  - A p0 read of addr 60 returns rvalid, `rdata` = 0 and `err` = 1.
  - With the macro undefined, `err` stays 0.
